// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART block sequencer.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StStream  = 2'd1,
    StRelease = 2'd2
  } ctrl_state_e;

  localparam int unsigned DEFAULT_BLOCK_SIZE = 129;
  localparam int unsigned HDR_ADDR           = 0;
  localparam int unsigned MAX_LEN            = DEFAULT_BLOCK_SIZE - 1;

endpackage

// File: rtl/uart_block_ctrl.sv
// Streams the payload of each received UART block to the softmax datapath, then releases
// the buffer; validates headers and keeps good/bad block counts plus a sticky overrun flag.
module uart_block_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
  parameter int unsigned ADDR_W     = $clog2(BLOCK_SIZE),
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              blk_ready,
  input  logic [7:0]        blk_count,
  input  logic              blk_overrun,
  output logic              consume,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  blocks_ok,
  output logic [7:0]        blocks_bad,
  output logic              overrun_seen
);

  localparam logic [7:0] FullCount = 8'(BLOCK_SIZE);
  localparam logic [7:0] LenMax    = 8'(BLOCK_SIZE - 1);

  ctrl_state_e       state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        len_q, len_d;
  logic              good_q, good_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]  ok_q, ok_d;
  logic [7:0]        bad_q, bad_d;
  logic              overrun_q, overrun_d;
  logic              len_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= 8'd0;
      len_q     <= 8'd0;
      good_q    <= 1'b0;
      rd_addr_q <= ADDR_W'(HDR_ADDR);
      ok_q      <= '0;
      bad_q     <= 8'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      good_q    <= good_d;
      rd_addr_q <= rd_addr_d;
      ok_q      <= ok_d;
      bad_q     <= bad_d;
      overrun_q <= overrun_d;
    end
  end

  // In IDLE the read address sits on the header, so rd_data is LEN.
  assign len_ok = (rd_data != 8'd0) && (rd_data <= LenMax);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    good_d    = good_q;
    rd_addr_d = rd_addr_q;
    ok_d      = ok_q;
    bad_d     = bad_q;
    overrun_d = overrun_q | blk_overrun;
    unique case (state_q)
      StIdle: begin
        if (enable && blk_ready) begin
          good_d = 1'b0;
          if ((blk_count == FullCount) && len_ok) begin
            len_d     = rd_data;
            idx_d     = 8'd1;
            rd_addr_d = ADDR_W'(1);
            state_d   = StStream;
          end else begin
            state_d = StRelease;
          end
        end
      end
      StStream: begin
        if (out_ready) begin
          if (idx_q == len_q) begin
            good_d  = 1'b1;
            state_d = StRelease;
          end else begin
            idx_d     = idx_q + 8'd1;
            rd_addr_d = ADDR_W'(idx_q + 8'd1);
          end
        end
      end
      StRelease: begin
        idx_d     = 8'd0;
        rd_addr_d = ADDR_W'(HDR_ADDR);
        if (good_q) begin
          ok_d = ok_q + CNT_W'(1);
        end else if (bad_q != 8'hff) begin
          bad_d = bad_q + 8'd1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid = (state_q == StStream);
    consume   = (state_q == StRelease);
    busy      = (state_q != StIdle);
    out_last  = (state_q == StStream) && (idx_q == len_q);
  end

  assign out_data     = rd_data;
  assign rd_addr      = rd_addr_q;
  assign blocks_ok    = ok_q;
  assign blocks_bad   = bad_q;
  assign overrun_seen = overrun_q;

endmodule

// File: tb/tb_uart_block_ctrl.sv
// Directed self-checking bench for uart_block_ctrl with a behavioural receive buffer.
module tb_uart_block_ctrl;

  logic        clk = 1'b0;
  logic        rst, enable, blk_ready, blk_overrun, out_ready;
  logic [7:0]  blk_count;
  logic        consume, out_valid, out_last, busy, overrun_seen;
  logic [7:0]  rd_addr, rd_data, out_data, blocks_bad;
  logic [15:0] blocks_ok;
  logic [7:0]  mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign rd_data = mem[rd_addr];

  uart_block_ctrl #(
    .BLOCK_SIZE(129),
    .ADDR_W    (8),
    .CNT_W     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .blk_ready   (blk_ready),
    .blk_count   (blk_count),
    .blk_overrun (blk_overrun),
    .consume     (consume),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .busy        (busy),
    .blocks_ok   (blocks_ok),
    .blocks_bad  (blocks_bad),
    .overrun_seen(overrun_seen)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a block and returns just after the edge that samples blk_ready.
  task automatic launch(input logic [7:0] len, input logic [7:0] cnt);
    mem[0]    = len;
    blk_count = cnt;
    blk_ready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if ({busy, out_valid, consume, out_last} !== 4'b0000 || rd_addr !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/valid/consume/last=%b%b%b%b rd_addr=%0d, want 0000 0",
               busy, out_valid, consume, out_last, rd_addr);
    end
    n_tests++;
    if (blocks_ok !== 16'd0 || blocks_bad !== 8'd0 || overrun_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cnt: ok=%0d bad=%0d ovr=%b, want 0 0 0",
               blocks_ok, blocks_bad, overrun_seen);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_block();
    out_ready = 1'b1;
    launch(8'd128, 8'd129);
    for (int k = 1; k <= 128; k++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== mem[k] || out_last !== (k == 128) ||
          consume !== 1'b0) begin
        n_fail++;
        $display("FAIL full_byte%0d: valid=%b data=%h last=%b consume=%b, want 1 %h %b 0",
                 k, out_valid, out_data, out_last, consume, mem[k], (k == 128));
      end
      step();
    end
    n_tests++;
    if (consume !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_consume: consume=%b valid=%b, want 1 0", consume, out_valid);
    end
    blk_ready = 1'b0;
    step();
    n_tests++;
    if (busy !== 1'b0 || consume !== 1'b0 || blocks_ok !== 16'd1 || rd_addr !== 8'd0) begin
      n_fail++;
      $display("FAIL full_done: busy=%b consume=%b ok=%0d rd_addr=%0d, want 0 0 1 0",
               busy, consume, blocks_ok, rd_addr);
    end
  endtask

  task automatic test_stall();
    logic rdy [5];
    int   eidx [5];
    rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    eidx = '{1, 2, 2, 2, 3};
    launch(8'd3, 8'd129);
    for (int c = 0; c < 5; c++) begin
      out_ready = rdy[c];
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== mem[eidx[c]] || out_last !== (c == 4)) begin
        n_fail++;
        $display("FAIL stall_cyc%0d: valid=%b data=%h last=%b, want 1 %h %b",
                 c, out_valid, out_data, out_last, mem[eidx[c]], (c == 4));
      end
      step();
    end
    n_tests++;
    if (consume !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_consume: consume=%b valid=%b, want 1 0", consume, out_valid);
    end
    blk_ready = 1'b0;
    out_ready = 1'b1;
    step();
    n_tests++;
    if (blocks_ok !== 16'd2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_done: ok=%0d busy=%b, want 2 0", blocks_ok, busy);
    end
  endtask

  task automatic test_bad_blocks();
    logic [7:0] lens [3];
    logic [7:0] cnts [3];
    lens = '{8'd0, 8'd200, 8'd3};
    cnts = '{8'd129, 8'd129, 8'd5};
    for (int b = 0; b < 3; b++) begin
      launch(lens[b], cnts[b]);
      n_tests++;
      if (consume !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bad%0d_release: consume=%b valid=%b busy=%b, want 1 0 1",
                 b, consume, out_valid, busy);
      end
      blk_ready = 1'b0;
      step();
    end
    n_tests++;
    if (blocks_bad !== 8'd3 || blocks_ok !== 16'd2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_counts: bad=%0d ok=%0d busy=%b, want 3 2 0",
               blocks_bad, blocks_ok, busy);
    end
  endtask

  task automatic test_overrun();
    n_tests++;
    if (overrun_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_initial: ovr=%b, want 0", overrun_seen);
    end
    launch(8'd5, 8'd129);
    for (int k = 1; k <= 5; k++) begin
      blk_overrun = (k == 2);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== mem[k] || out_last !== (k == 5)) begin
        n_fail++;
        $display("FAIL ovr_byte%0d: valid=%b data=%h last=%b, want 1 %h %b",
                 k, out_valid, out_data, out_last, mem[k], (k == 5));
      end
      step();
    end
    blk_overrun = 1'b0;
    n_tests++;
    if (overrun_seen !== 1'b1 || consume !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sticky: ovr=%b consume=%b, want 1 1", overrun_seen, consume);
    end
    blk_ready = 1'b0;
    step();
    launch(8'd2, 8'd129);
    step();
    step();
    blk_ready = 1'b0;
    step();
    n_tests++;
    if (overrun_seen !== 1'b1 || blocks_ok !== 16'd4 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_persist: ovr=%b ok=%0d busy=%b, want 1 4 0",
               overrun_seen, blocks_ok, busy);
    end
  endtask

  task automatic test_reset_mid_stream();
    launch(8'd100, 8'd129);
    repeat (39) step();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== mem[40] || rd_addr !== 8'd40) begin
      n_fail++;
      $display("FAIL rstmid_byte40: valid=%b data=%h addr=%0d, want 1 %h 40",
               out_valid, out_data, rd_addr, mem[40]);
    end
    rst = 1'b1;
    step();
    rst       = 1'b0;
    blk_ready = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || rd_addr !== 8'd0 || consume !== 1'b0 ||
        blocks_ok !== 16'd0 || blocks_bad !== 8'd0 || overrun_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_state: busy=%b valid=%b addr=%0d consume=%b ok=%0d bad=%0d ovr=%b",
               busy, out_valid, rd_addr, consume, blocks_ok, blocks_bad, overrun_seen);
    end
    step();
    launch(8'd4, 8'd129);
    for (int k = 1; k <= 4; k++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== mem[k] || out_last !== (k == 4)) begin
        n_fail++;
        $display("FAIL rstmid_new%0d: valid=%b data=%h last=%b, want 1 %h %b",
                 k, out_valid, out_data, out_last, mem[k], (k == 4));
      end
      step();
    end
    blk_ready = 1'b0;
    step();
    n_tests++;
    if (blocks_ok !== 16'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_done: ok=%0d busy=%b, want 1 0", blocks_ok, busy);
    end
  endtask

  task automatic test_enable();
    enable    = 1'b0;
    mem[0]    = 8'd2;
    blk_count = 8'd129;
    blk_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_tests++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL en_hold%0d: busy=%b valid=%b, want 0 0", c, busy, out_valid);
      end
    end
    enable = 1'b1;
    step();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== mem[1]) begin
      n_fail++;
      $display("FAIL en_start: valid=%b data=%h, want 1 %h", out_valid, out_data, mem[1]);
    end
    enable = 1'b0;
    step();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== mem[2] || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL en_drop_stream: valid=%b data=%h last=%b, want 1 %h 1",
               out_valid, out_data, out_last, mem[2]);
    end
    step();
    blk_ready = 1'b0;
    enable    = 1'b1;
    n_tests++;
    if (consume !== 1'b1) begin
      n_fail++;
      $display("FAIL en_consume: consume=%b, want 1", consume);
    end
    step();
    n_tests++;
    if (blocks_ok !== 16'd2) begin
      n_fail++;
      $display("FAIL en_done: ok=%0d, want 2", blocks_ok);
    end
  endtask

  task automatic test_bad_saturate();
    for (int b = 0; b < 300; b++) begin
      launch(8'd0, 8'd129);
      blk_ready = 1'b0;
      step();
      if (b == 253) begin
        n_tests++;
        if (blocks_bad !== 8'd254) begin
          n_fail++;
          $display("FAIL sat_254: bad=%0d, want 254", blocks_bad);
        end
      end
    end
    n_tests++;
    if (blocks_bad !== 8'd255 || blocks_ok !== 16'd2) begin
      n_fail++;
      $display("FAIL sat_255: bad=%0d ok=%0d, want 255 2", blocks_bad, blocks_ok);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    rst         = 1'b1;
    enable      = 1'b1;
    blk_ready   = 1'b0;
    blk_count   = 8'd0;
    blk_overrun = 1'b0;
    out_ready   = 1'b1;
    #1;
    test_reset();
    test_full_block();
    test_stall();
    test_bad_blocks();
    test_overrun();
    test_reset_mid_stream();
    test_enable();
    test_bad_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
